// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external ALU between NREQ requesters
// and returns each result on a valid/ready response channel.
module alu_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*5-1:0]    req_fs,
    input  logic [NREQ*5-1:0]    req_sh,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [4:0]           alu_fs,
    output logic [4:0]           alu_sh,
    input  logic [31:0]          alu_f,
    input  logic                 alu_z,
    input  logic                 alu_v,
    input  logic                 alu_n,
    input  logic                 alu_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_f,
    output logic [3:0]           rsp_flags,
    output logic                 busy,
    output logic [COUNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [IDW-1:0] rr_last;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           accept;

    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic [4:0]     sel_fs;
    logic [4:0]     sel_sh;

    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [4:0]     op_fs;
    logic [4:0]     op_sh;

    // Round-robin: the lowest valid index above rr_last wins; otherwise wrap to the lowest valid index.
    always_comb begin
        logic           upper_found;
        logic           lower_found;
        logic [IDW-1:0] upper_idx;
        logic [IDW-1:0] lower_idx;
        upper_found = 1'b0;
        lower_found = 1'b0;
        upper_idx   = '0;
        lower_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) > rr_last)) begin
                upper_found = 1'b1;
                upper_idx   = IDW'(i);
            end
            if (req_valid[i]) begin
                lower_found = 1'b1;
                lower_idx   = IDW'(i);
            end
        end
        grant_found = lower_found;
        grant_idx   = upper_found ? upper_idx : lower_idx;
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_fs = '0;
        sel_sh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_fs = req_fs[5*i +: 5];
                sel_sh = req_sh[5*i +: 5];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The only combinational output path is req_valid -> req_ready, and only while IDLE.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy   = 1'b0;
                accept = grant_found;
                if (grant_found) req_ready[grant_idx] = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= IDW'(NREQ - 1);
            op_a    <= '0;
            op_b    <= '0;
            op_fs   <= '0;
            op_sh   <= '0;
            rsp_id  <= '0;
        end else if (accept) begin
            rr_last <= grant_idx;
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_fs   <= sel_fs;
            op_sh   <= sel_sh;
            rsp_id  <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_f     <= '0;
            rsp_flags <= '0;
        end else if (state == EXEC) begin
            rsp_f     <= alu_f;
            rsp_flags <= {alu_z, alu_v, alu_n, alu_c};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if ((state == RESP) && rsp_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_fs = op_fs;
    assign alu_sh = op_sh;

endmodule
